// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register-index types, the register-file write
// arbiter state enum and a saturating counter helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef logic [7:0]  cnt_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic cnt_t sat_inc(
    input cnt_t c,
    input cnt_t m
  );
    return (c >= m) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way write-port grant logic (purely combinational).
// In: valid, rr, state, owner, cnt. Out: grant (one-hot/zero), force_rel.
module rr_arb2
  import cpu_types_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic [1:0] valid,
  input  logic       rr,
  input  arb_state_t state,
  input  logic       owner,
  input  cnt_t       cnt,
  output logic [1:0] grant,
  output logic       force_rel
);

  // cnt counts beats already taken; the owner beat now in
  // flight brings it to cnt+1, so release once that hits max.
  localparam cnt_t LMAX_M1 = cnt_t'(LOCK_MAX - 1);

  logic other_v;

  always_comb begin
    grant     = 2'b00;
    force_rel = 1'b0;
    other_v   = owner ? valid[0] : valid[1];
    unique case (state)
      LOCKED: begin
        grant = owner ? {valid[1], 1'b0}
                      : {1'b0, valid[0]};
        force_rel = other_v && (cnt >= LMAX_M1);
      end
      default: begin
        unique case (valid)
          2'b11:   grant = rr ? 2'b10 : 2'b01;
          default: grant = valid;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between the writeback pipe
// (req 0) and the multicycle/load unit (req 1), with lockable
// multi-beat sequences and a bounded lock length.
// Ports: CLK, RST (async, high); req_valid/req_lock/req_sel*/req_dat*
// in; req_ready out; rf_WEN/rf_wsel/rf_wdat registered write port;
// locked/owner expose the lock state.
module rf_write_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_lock,
  input  logic [4:0]  req_sel0,
  input  logic [4:0]  req_sel1,
  input  logic [31:0] req_dat0,
  input  logic [31:0] req_dat1,
  output logic [1:0]  req_ready,
  output logic        rf_WEN,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic        locked,
  output logic        owner
);

  localparam cnt_t LMAX = cnt_t'(LOCK_MAX);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  cnt_t       cnt_q, cnt_d;
  logic       wen_q, wen_d;
  regbits_t   wsel_q, wsel_d;
  word_t      wdat_q, wdat_d;

  logic [1:0] grant;
  logic       force_rel;
  logic       beat;
  logic       gidx;
  regbits_t   b_sel;
  word_t      b_dat;

  rr_arb2 #(
    .LOCK_MAX (LOCK_MAX)
  ) u_arb (
    .valid     (req_valid),
    .rr        (rr_q),
    .state     (state_q),
    .owner     (owner_q),
    .cnt       (cnt_q),
    .grant     (grant),
    .force_rel (force_rel)
  );

  assign req_ready = grant;
  assign beat      = |grant;
  assign gidx      = grant[1];
  assign b_sel     = gidx ? req_sel1 : req_sel0;
  assign b_dat     = gidx ? req_dat1 : req_dat0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    // x0 writes are consumed but never reach the file
    wen_d   = beat && (b_sel != 5'd0);
    wsel_d  = wen_d ? b_sel : wsel_q;
    wdat_d  = wen_d ? b_dat : wdat_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          rr_d = ~gidx;
          if (req_lock[gidx]) begin
            state_d = LOCKED;
            owner_d = gidx;
            cnt_d   = 8'd1;
          end
        end
      end
      default: begin
        if (beat) begin
          cnt_d = sat_inc(cnt_q, LMAX);
          if (!req_lock[owner_q] || force_rel) begin
            state_d = IDLE;
            owner_d = 1'b0;
            cnt_d   = 8'd0;
            rr_d    = ~owner_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= 8'd0;
      wen_q   <= 1'b0;
      wsel_q  <= 5'd0;
      wdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      wsel_q  <= wsel_d;
      wdat_q  <= wdat_d;
    end
  end

  assign rf_WEN  = wen_q;
  assign rf_wsel = wsel_q;
  assign rf_wdat = wdat_q;
  assign locked  = (state_q == LOCKED);
  assign owner   = owner_q;

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-002 Parameter: LOCK_MAX, 8, maximum consecutive locked beats before forced release when the other requester waits (legal range 1..255).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  2  per-requester write request (bit 0 = writeback pipe, bit 1 = multicycle/load unit).
REQ-006 req_lock  input  2  per-requester: hold grant after this beat (multi-word sequence).
REQ-007 req_sel0, req_sel1  input  5 each  destination register index.
REQ-008 req_dat0, req_dat1  input  32 each  write data (word_t).
REQ-009 req_ready  output  2  per-requester accept; beat transfers when valid and ready are both high at a rising edge.
REQ-010 rf_WEN  output  1  register-file write enable, registered.
REQ-011 rf_wsel  output  5  register-file write select, registered.
REQ-012 rf_wdat  output  32  register-file write data, registered.
REQ-013 locked  output  1  high while the state machine is in LOCKED.
REQ-014 owner  output  1  index of the lock holder; 0 when not locked.

Function
REQ-015 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be combinational from req_valid, state, rr pointer and counter.
REQ-016 IDLE, one valid: grant that requester.
REQ-017 IDLE, both valid: grant the requester indicated by the rr pointer (reset 0); after any IDLE grant, rr SHALL point at the non-granted requester.
REQ-018 IDLE grant with req_lock high on the accepted beat SHALL move the state to LOCKED with owner = granted index and cnt = 1.
REQ-019 LOCKED: only owner SHALL be granted; the other requester SHALL see ready low even when the owner's valid is low (bubble, lock held).
REQ-020 LOCKED owner beat: cnt increments, saturating at LOCK_MAX.
REQ-021 LOCKED exit to IDLE SHALL occur after an accepted owner beat with req_lock low.
REQ-022 LOCKED exit to IDLE SHALL occur after an accepted owner beat when cnt == LOCK_MAX and the other valid is high, regardless of req_lock; rr then points at the other requester.
REQ-023 An accepted beat SHALL produce rf_WEN=1 with its rf_wsel/rf_wdat exactly one cycle later, for exactly one cycle.
REQ-024 With no accepted beat, rf_WEN SHALL be 0; rf_wsel/rf_wdat hold their last values.
REQ-025 A beat with sel == 0 SHALL be accepted and counted but SHALL produce rf_WEN=0.
REQ-026 Back-to-back accepted beats SHALL produce back-to-back writes with no bubble; throughput is one write per cycle.

Reset
REQ-027 RST high SHALL immediately force: state IDLE, rr 0, cnt 0, rf_WEN 0, rf_wsel 0, rf_wdat 0, locked 0, owner 0.
REQ-028 Reset mid-lock or with a registered write pending SHALL discard that write (no rf_WEN after release); arbitration restarts from IDLE on the first rising edge after RST falls.

Structure
REQ-029 word_t (32-bit) and regbits_t (5-bit) SHALL come from cpu_types_pkg; arb_state_t enum {IDLE, LOCKED} SHALL be added to cpu_types_pkg.
REQ-030 The grant decision SHALL be a combinational sub-module rr_arb2 (inputs: valid, rr, state, owner, cnt; outputs: grant); state, counter and output registers stay in rf_write_arbiter.

Verification
REQ-031 Both valid, no lock, 4 cycles, sel0=3/dat0=0xA, sel1=4/dat1=0xB -> grants 0,1,0,1; rf_WEN=1 each following cycle with wsel 3,4,3,4.
REQ-032 req0 lock=1 for 3 beats then lock=0, req1 valid throughout -> req1 ready low for 4 beats; req1 granted on the 5th cycle; locked falls after req0's 4th beat.
REQ-033 LOCK_MAX=2, req0 lock held high, req1 valid -> forced release after req0's 2nd beat; req1 granted next; rr=0 afterward.
REQ-034 Accepted beat sel=0 dat=0xFFFFFFFF -> req_ready high, rf_WEN stays 0 next cycle.
REQ-035 RST asserted the cycle after an accepted beat during LOCKED -> rf_WEN 0, locked 0, owner 0 immediately; no write appears after RST falls.
